// File: rtl/obi_axil_bridge.sv
// OBI to AXI4-Lite master bridge with in-order responses and a bounded outstanding count.
// Optional feature: define OBI_AXIL_BRIDGE_ERR_EN to report resp[1] of R/B beats on err_o.
module obi_axil_bridge #(
    parameter int          ADDR_W          = 32,
    parameter int          DATA_W          = 32,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [2:0]  PROT            = 3'b000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt_s, r_hs_s, b_hs_s, resp_hs_s;

    // A direction switch waits until every earlier response is back, which keeps R and B ordered.
    assign gnt_s = (state_q == IDLE) & req_i & (cnt_q < CNT_MAX)
                 & ((cnt_q == CNT_ZERO) | (dir_q == we_i));

    assign b_hs_s    = m_axi_bvalid & (cnt_q != CNT_ZERO);
    assign r_hs_s    = m_axi_rvalid & (cnt_q != CNT_ZERO);
    assign resp_hs_s = b_hs_s | r_hs_s;

    // Next-state logic for the command FSM, outstanding counter and response path.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        case (state_q)
            IDLE: begin
                if (gnt_s) begin
                    addr_d    = addr_i;
                    be_d      = be_i;
                    wdata_d   = wdata_i;
                    dir_d     = we_i;
                    awvalid_d = we_i;
                    wvalid_d  = we_i;
                    arvalid_d = ~we_i;
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                // A cleared valid doubles as the done flag for its channel.
                if (dir_q) begin
                    awvalid_d = awvalid_q & ~m_axi_awready;
                    wvalid_d  = wvalid_q & ~m_axi_wready;
                    if (!awvalid_d && !wvalid_d) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    arvalid_d = arvalid_q & ~m_axi_arready;
                    if (!arvalid_d) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (gnt_s && !resp_hs_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!gnt_s && resp_hs_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        rvalid_d = resp_hs_s;
        if (r_hs_s) begin
            rdata_d = m_axi_rdata;
        end else begin
            rdata_d = {DATA_W{1'b0}};
        end
    end

`ifdef OBI_AXIL_BRIDGE_ERR_EN
    logic err_q, err_d;

    // Error flag taken from the returning beat; only one of R/B can be live at a time.
    always_comb begin
        if (r_hs_s) begin
            err_d = m_axi_rresp[1];
        end else if (b_hs_s) begin
            err_d = m_axi_bresp[1];
        end else begin
            err_d = 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_resp_s;
    assign unused_resp_s = ^{m_axi_rresp, m_axi_bresp};
    assign err_o = 1'b0;
`endif

    // State and output registers; reset clears every valid asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            cnt_q     <= CNT_ZERO;
            addr_q    <= {ADDR_W{1'b0}};
            be_q      <= {BE_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
`ifdef OBI_AXIL_BRIDGE_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
`ifdef OBI_AXIL_BRIDGE_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign gnt_o         = gnt_s;
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = be_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT;
    assign m_axi_bready  = 1'b1;
    assign m_axi_rready  = 1'b1;

    obi_axil_bridge_chk u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .beat_i     (m_axi_bvalid | m_axi_rvalid),
        .cnt_zero_i (cnt_q == CNT_ZERO)
    );
endmodule

// Flags an R/B beat that arrives with nothing outstanding; such beats are dropped.
module obi_axil_bridge_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic beat_i,
    input logic cnt_zero_i
);
    a_no_orphan_beat: assert property (@(posedge clk_i) disable iff (!rst_ni) !(beat_i && cnt_zero_i));
endmodule

// File: tb/tb_obi_axil_bridge.sv
// Directed bench for obi_axil_bridge: a reactive AXI-Lite slave, a transaction-level model
// of grants and ordered responses, and a per-cycle compare against that model.
module tb_obi_axil_bridge;
    localparam int MAXO = 2;
    localparam logic [2:0] PROT = 3'b000;
`ifdef OBI_AXIL_BRIDGE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni, req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [3:0] be_i;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0] wstrb;
    logic [2:0] awprot, arprot;
    logic [1:0] bresp, rresp;

    obi_axil_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .PROT(PROT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic is_rd; logic [31:0] data; logic [1:0] resp; } beat_t;
    typedef struct { logic [31:0] data; logic err; } exp_t;

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];
    beat_t resp_q[$];
    exp_t  exp_q[$];

    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int budget = 1000;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    int mdl_out = 0, b_beats = 0;
    logic mdl_dir = 1'b0, pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0, exp_rv = 1'b0;
    logic aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
    logic [31:0] cur_addr = 32'h0, cur_data = 32'h0;
    logic [3:0] cur_be = 4'h0;
    logic aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] got_addr = 32'h0, got_data = 32'h0;
    logic [3:0] got_strb = 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_mdl(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
    endfunction

    // Edge monitor: slave memory/response queue plus the transaction-level model.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_q.delete(); exp_q.delete();
            mdl_out = 0; exp_rv = 1'b0; pend_aw = 1'b0; pend_w = 1'b0; pend_ar = 1'b0;
            aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        end else begin
            if (arvalid && arready) begin
                resp_q.push_back('{is_rd: 1'b1, data: rd_slv(araddr), resp: rresp_cfg});
                pend_ar = 1'b0;
            end
            if (awvalid && awready) begin aw_got = 1'b1; got_addr = awaddr; pend_aw = 1'b0; end
            if (wvalid && wready) begin w_got = 1'b1; got_data = wdata; got_strb = wstrb; pend_w = 1'b0; end
            if (aw_got && w_got) begin
                slv_mem[got_addr] = merge(rd_slv(got_addr), got_data, got_strb);
                resp_q.push_back('{is_rd: 1'b0, data: 32'h0, resp: bresp_cfg});
                aw_got = 1'b0; w_got = 1'b0;
            end
            exp_rv = 1'b0;
            if ((rvalid && rready) || (bvalid && bready)) begin
                if (resp_q.size() > 0) resp_q.delete(0);
                if (bvalid) b_beats++;
                budget--; mdl_out--; exp_rv = 1'b1;
            end
            if (req_i && gnt_o) begin
                mdl_out++; mdl_dir = we_i;
                pend_aw = we_i; pend_w = we_i; pend_ar = !we_i;
                cur_addr = addr_i; cur_data = wdata_i; cur_be = be_i;
                if (we_i) begin
                    mdl_mem[addr_i] = merge(rd_mdl(addr_i), wdata_i, be_i);
                    exp_q.push_back('{data: 32'h0, err: bresp_cfg[1] & ERR_EN});
                end else begin
                    exp_q.push_back('{data: rd_mdl(addr_i), err: rresp_cfg[1] & ERR_EN});
                end
            end
            aw_stall = awvalid & ~awready;
            w_stall  = wvalid & ~wready;
            ar_stall = arvalid & ~arready;
        end
    end

    // Slave driver: readies after a programmable wait, responses gated by a beat budget.
    initial begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                awready = awvalid && (aw_cnt >= aw_wait); aw_cnt = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid  && (w_cnt  >= w_wait);  w_cnt  = wvalid  ? w_cnt + 1  : 0;
                arready = arvalid && (ar_cnt >= ar_wait); ar_cnt = arvalid ? ar_cnt + 1 : 0;
                if (resp_q.size() > 0 && budget > 0) begin
                    rvalid = resp_q[0].is_rd;  bvalid = !resp_q[0].is_rd;
                    rdata = resp_q[0].data;    rresp = resp_q[0].resp; bresp = resp_q[0].resp;
                end else begin
                    rvalid = 1'b0; bvalid = 1'b0; rdata = 32'h0;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    initial begin
        exp_t e;
        logic exp_gnt;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni) begin
                exp_gnt = req_i && !(pend_aw || pend_w || pend_ar) && (mdl_out < MAXO)
                          && (mdl_out == 0 || mdl_dir == we_i);
                check("gnt", gnt_o, exp_gnt);
                check("rvalid_o", rvalid_o, exp_rv);
                if (exp_rv) begin
                    if (exp_q.size() == 0) fail("resp_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("rdata_o", rdata_o, e.data);
                        check("err_o", err_o, e.err);
                    end
                end
                check("bready", bready, 1'b1);
                check("rready", rready, 1'b1);
                check("awprot", awprot, PROT);
                check("arprot", arprot, PROT);
                if (aw_stall) check("aw_hold", awvalid, 1'b1);
                if (w_stall)  check("w_hold", wvalid, 1'b1);
                if (ar_stall) check("ar_hold", arvalid, 1'b1);
                if (awvalid) check("awaddr", awaddr, cur_addr);
                if (wvalid) begin check("wdata", wdata, cur_data); check("wstrb", wstrb, cur_be); end
                if (arvalid) check("araddr", araddr, cur_addr);
            end
        end
    end

    task automatic drive_req(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; addr_i = a; we_i = we; be_i = be; wdata_i = d;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        #1;
        while (!gnt_o && n < 50) begin @(negedge clk_i); #1; n++; end
        if (!gnt_o) fail("gnt_timeout");
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic wait_rv(output int n, output logic [31:0] d, output logic e);
        n = 0; d = 32'h0; e = 1'b0;
        do begin @(negedge clk_i); #1; n++; end while (!rvalid_o && n < 50);
        if (!rvalid_o) fail("rvalid_timeout");
        else begin d = rdata_o; e = err_o; end
    endtask

    task automatic do_xfer(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                           output logic [31:0] d, output logic e);
        int n;
        drive_req(a, we, be, wd);
        wait_gnt(n);
        wait_rv(n, d, e);
    endtask

    initial begin
        int n, b0;
        logic [31:0] d;
        logic e;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0;
        logic [31:0] d;
        logic e;
        rst_ni = 1'b0; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0;
        slv_mem[32'h100] = 32'hDEADBEEF; mdl_mem[32'h100] = 32'hDEADBEEF;
        slv_mem[32'h104] = 32'h0BADF00D; mdl_mem[32'h104] = 32'h0BADF00D;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_gnt", gnt_o, 1'b0);       check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);   check("rst_arvalid", arvalid, 1'b0);
        check("rst_bready", bready, 1'b1);   check("rst_rready", rready, 1'b1);
        check("rst_rvalid_o", rvalid_o, 1'b0); check("rst_err_o", err_o, 1'b0);
        check("rst_rdata_o", rdata_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read with minimum latency.
        drive_req(32'h100, 1'b0, 4'hF, 32'h0);
        #1; check("t1_gnt_c0", gnt_o, 1'b1);
        wait_gnt(n);
        #1; check("t1_arvalid_c1", arvalid, 1'b1); check("t1_araddr_c1", araddr, 32'h100);
        wait_rv(n, d, e);
        check("t1_latency", n, 2); check("t1_rdata", d, 32'hDEADBEEF); check("t1_err", e, 1'b0);

        // Split write: W accepted at once, AW held off until cycle 4.
        aw_wait = 3; b0 = b_beats;
        drive_req(32'h200, 1'b1, 4'hF, 32'h12345678);
        wait_gnt(n);
        #1; check("t2_awvalid_c1", awvalid, 1'b1); check("t2_wvalid_c1", wvalid, 1'b1);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk_i); #1;
            check("t2_awvalid", awvalid, (c < 5) ? 1'b1 : 1'b0);
            check("t2_wvalid", wvalid, 1'b0);
        end
        wait_rv(n, d, e);
        check("t2_rdata_zero", d, 32'h0);
        repeat (3) @(negedge clk_i);
        check("t2_one_b", b_beats - b0, 1);
        aw_wait = 0;

        // Byte-enable merge, read back.
        do_xfer(32'h100, 1'b1, 4'b0101, 32'hAABBCCDD, d, e);
        do_xfer(32'h100, 1'b0, 4'hF, 32'h0, d, e);
        check("t2_merged", d, 32'hDEBBBEDD);

        // Outstanding limit with responses withheld.
        budget = 0;
        drive_req(32'h100, 1'b0, 4'hF, 32'h0); wait_gnt(n);
        drive_req(32'h200, 1'b0, 4'hF, 32'h0); wait_gnt(n);
        drive_req(32'h104, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin #1; check("t3_gnt_blocked", gnt_o, 1'b0); @(negedge clk_i); end
        #1; budget = 1;
        wait_gnt(n);
        check("t3_gnt_lat", n, 2);
        #1; budget = 1000;
        wait_rv(n, d, e); check("t3_rd2", d, 32'h12345678);
        wait_rv(n, d, e); check("t3_rd3", d, 32'h0BADF00D);

        // Direction switch waits for B.
        budget = 0;
        drive_req(32'h300, 1'b1, 4'hF, 32'hCAFEF00D); wait_gnt(n);
        drive_req(32'h300, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin #1; check("t4_gnt_blocked", gnt_o, 1'b0); @(negedge clk_i); end
        #1; budget = 1000;
        wait_gnt(n);
        wait_rv(n, d, e); check("t4_rdata", d, 32'hCAFEF00D);

        // Error responses.
        rresp_cfg = 2'b10;
        do_xfer(32'h104, 1'b0, 4'hF, 32'h0, d, e);
        check("t5_rd_err", e, ERR_EN); check("t5_rd_data", d, 32'h0BADF00D);
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        do_xfer(32'h108, 1'b1, 4'hF, 32'h55AA55AA, d, e);
        check("t5_wr_err", e, ERR_EN);
        bresp_cfg = 2'b00;

        // Reset while AW is pending.
        aw_wait = 1000;
        drive_req(32'h400, 1'b1, 4'hF, 32'h11111111); wait_gnt(n);
        #1; check("t6_awvalid_pre", awvalid, 1'b1);
        #2; rst_ni = 1'b0;
        #1;
        check("t6_awvalid", awvalid, 1'b0); check("t6_wvalid", wvalid, 1'b0);
        check("t6_arvalid", arvalid, 1'b0); check("t6_rvalid_o", rvalid_o, 1'b0);
        check("t6_gnt", gnt_o, 1'b0);
        repeat (2) @(negedge clk_i);
        aw_wait = 0; rst_ni = 1'b1;
        do_xfer(32'h200, 1'b0, 4'hF, 32'h0, d, e);
        check("t6_rdata", d, 32'h12345678); check("t6_err", e, 1'b0);

        repeat (5) @(negedge clk_i);
        check("end_exp_empty", exp_q.size(), 0);
        check("end_resp_empty", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
